// File: rtl/spdif_pkg.sv
// Shared constants, FSM encoding and NCO increment helper for the S/PDIF transmit controller.
package spdif_pkg;

    localparam int unsigned BITRATE_44K1 = 32'd5_644_800;
    localparam int unsigned BITRATE_48K  = 32'd6_144_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // floor(bitrate * 2^w / clk_hz), evaluated at elaboration in 64 bits
    function automatic logic [63:0] nco_inc(input logic [63:0] bitrate,
                                            input logic [63:0] clk_hz,
                                            input int unsigned w);
        return (bitrate << w) / clk_hz;
    endfunction

endpackage

// File: rtl/spdif_bitclk_nco.sv
// Phase-accumulator NCO producing a registered single-cycle bit-rate enable from its carry-out.
module spdif_bitclk_nco
    import spdif_pkg::*;
#(
    parameter int unsigned NCO_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             run_i,
    input  logic [NCO_W-1:0] inc_i,
    output logic             bit_en_o
);

    logic [NCO_W-1:0] r_acc;
    logic             r_bit_en;
    logic [NCO_W:0]   w_sum;

    assign w_sum    = {1'b0, r_acc} + {1'b0, inc_i};
    assign bit_en_o = r_bit_en;

    // Accumulate while running; the carry out of the top bit is the enable pulse
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_acc    <= {NCO_W{1'b0}};
            r_bit_en <= 1'b0;
        end else if (run_i) begin
            r_acc    <= w_sum[NCO_W-1:0];
            r_bit_en <= w_sum[NCO_W];
        end else begin
            r_bit_en <= 1'b0;
        end
    end

endmodule

// File: rtl/spdif_tx_ctrl.sv
// S/PDIF transmit sequencer: run/drain FSM, per-frame sample scheduling from a stream or a
// square-wave test tone, underrun handling and the bit-rate NCO.
module spdif_tx_ctrl
    import spdif_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 50_000_000,
    parameter int unsigned NCO_W            = 32,
    parameter bit          UNDERRUN_REPEAT  = 1'b1,
    parameter logic [15:0] TONE_AMP         = 16'h2000,
    parameter int unsigned TONE_HALF_FRAMES = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        rate_sel_i,
    input  logic        src_sel_i,
    input  logic        s_valid_i,
    input  logic [31:0] s_data_i,
    output logic        s_ready_o,
    output logic        tx_rst_o,
    output logic        tx_bit_en_o,
    output logic [31:0] tx_sample_o,
    input  logic        tx_sample_req_i,
    output logic        busy_o,
    output logic        underrun_o,
    output logic [15:0] underrun_cnt_o
);

    localparam logic [63:0] INC_44K1 = nco_inc(64'(BITRATE_44K1), 64'(CLK_HZ), NCO_W);
    localparam logic [63:0] INC_48K  = nco_inc(64'(BITRATE_48K), 64'(CLK_HZ), NCO_W);
    localparam int unsigned TONE_CNT_W = $clog2(TONE_HALF_FRAMES + 1);
    localparam logic [TONE_CNT_W-1:0] TONE_LAST = TONE_CNT_W'(TONE_HALF_FRAMES - 1);

    state_t                r_state;
    logic                  r_rate_sel;
    logic                  r_src_sel;
    logic [31:0]           r_sample;
    logic [TONE_CNT_W-1:0] r_tone_cnt;
    logic                  r_tone_neg;
    logic                  r_underrun;
    logic [15:0]           r_underrun_cnt;

    logic [NCO_W-1:0]      w_inc;
    logic [15:0]           w_tone_v;
    logic                  w_nco_clr;
    logic                  w_nco_run;
    logic                  w_accept;

    assign w_inc     = r_rate_sel ? INC_48K[NCO_W-1:0] : INC_44K1[NCO_W-1:0];
    assign w_tone_v  = r_tone_neg ? (16'd0 - TONE_AMP) : TONE_AMP;
    // Clear while idle and on the DRAIN exit so no enable leaks into the first IDLE cycle
    assign w_nco_clr = (r_state != RUN) && !((r_state == DRAIN) && !tx_sample_req_i);
    assign w_nco_run = (r_state == RUN) || (r_state == DRAIN);
    assign w_accept  = (r_state == RUN) && tx_sample_req_i && !r_src_sel && s_valid_i;

    assign s_ready_o      = w_accept;
    assign tx_rst_o       = (r_state == IDLE);
    assign busy_o         = (r_state == RUN) || (r_state == DRAIN);
    assign tx_sample_o    = r_sample;
    assign underrun_o     = r_underrun;
    assign underrun_cnt_o = r_underrun_cnt;

    spdif_bitclk_nco #(
        .NCO_W (NCO_W)
    ) u_nco (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (w_nco_clr),
        .run_i    (w_nco_run),
        .inc_i    (w_inc),
        .bit_en_o (tx_bit_en_o)
    );

    // Link FSM with sample register, tone generator and underrun bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_rate_sel     <= 1'b0;
            r_src_sel      <= 1'b0;
            r_sample       <= 32'h0;
            r_tone_cnt     <= {TONE_CNT_W{1'b0}};
            r_tone_neg     <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 16'h0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sample <= 32'h0;
                    if (enable_i) begin
                        r_state    <= RUN;
                        r_rate_sel <= rate_sel_i;
                        r_src_sel  <= src_sel_i;
                    end
                end
                RUN: begin
                    if (tx_sample_req_i) begin
                        if (r_src_sel) begin
                            r_sample <= {w_tone_v, w_tone_v};
                            if (r_tone_cnt == TONE_LAST) begin
                                r_tone_cnt <= {TONE_CNT_W{1'b0}};
                                r_tone_neg <= ~r_tone_neg;
                            end else begin
                                r_tone_cnt <= r_tone_cnt + TONE_CNT_W'(1);
                            end
                        end else if (s_valid_i) begin
                            r_sample <= s_data_i;
                        end else begin
                            r_sample   <= UNDERRUN_REPEAT ? r_sample : 32'h0;
                            r_underrun <= 1'b1;
                            if (r_underrun_cnt != 16'hFFFF) begin
                                r_underrun_cnt <= r_underrun_cnt + 16'd1;
                            end
                        end
                    end else if (!enable_i) begin
                        r_sample <= 32'h0;
                    end
                    if (!enable_i) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_sample <= 32'h0;
                    if (tx_sample_req_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_sample <= 32'h0;
                end
            endcase
        end
    end

endmodule
